tile_map_ctl: RTL and testbench
===============================

Name: tile_map_ctl

Overview:
- Owns the 32x24 game tile map and feeds the tile renderer with a per-pixel texture_number and inversion flag.
- Shares the map's read/write port between two game-logic requesters (player/bomb engines) using round-robin req/ack arbitration.
- Writes the default arena layout after reset.
- Generates the bomb-blink inversion from a vsync-based frame counter.

Parameters:
- BLINK_FRAMES, 15, number of vsync rising edges per blink half-period (>=1).
- MAP_COLS, 32, tiles per row; fixed, equals 1024/32.
- MAP_ROWS, 24, tile rows; fixed, equals 768/32.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hcount  in  11  renderer pixel column
- vcount  in  11  renderer pixel row
- vsync  in  1  frame sync, used for blink timing
- texture_number  out  3  tile code for (hcount,vcount), 1 cycle latency
- inversion  out  1  invert tile colours, aligned with texture_number
- req0 / req1  in  1  access request, held until ack
- we0 / we1  in  1  1 = write, 0 = read
- col0 / col1  in  5  tile column 0..31
- row0 / row1  in  5  tile row 0..23
- wdata0 / wdata1  in  3  tile code to write
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata  out  3  read result, valid while the matching ack is high
- init_done  out  1  map initialised; requests are served only when high

Behaviour:
- Reset values: all outputs 0, FSM=INIT, init counter=0, last_grant=1, blink phase=0, frame counter=0.
- Tile address = row*32 + col (10 bits, 768 entries, 3-bit data).
- Render port:
  - Registered each cycle: texture_number = map[vcount[9:5]*32 + hcount[9:5]].
  - Output is forced to 0 when vcount>=768, hcount>=1024, or init_done=0.
  - The render read is independent of the arbiter.
  - A same-cycle write to the same address returns the old data (read-first).
- inversion: registered alongside texture_number; equals blink_phase AND (tile==TEX_BOMB).
- Blink: register vsync and detect rising edges.
  - Each edge increments the frame counter.
  - At BLINK_FRAMES-1 the counter wraps to 0 and blink_phase toggles.
- FSM:
  - INIT: writes one entry per cycle at address init_cnt.
    - Border cells (row 0, row 23, col 0, col 31) and cells with even row and even col get TEX_WALL. All others get TEX_EMPTY.
    - After address 767, go to IDLE. init_done is set on entry to IDLE, 768 cycles after reset release.
    - Requests are not acked during INIT.
  - IDLE: if exactly one req is high, grant it. If both are high, grant the requester != last_grant.
    - On a grant: latch we/row/col/wdata, update last_grant, go to ACCESS.
  - ACCESS: perform the RAM op on the shared port, then go to RESP.
    - Writes with row>=24 are suppressed.
  - RESP: pulse ack of the granted requester.
    - rdata = read value for reads; 0 for writes and for row>=24 reads. rdata holds its value otherwise.
    - Then go to IDLE.
- Throughput is one access per 3 cycles; ack comes 2 cycles after req is sampled in IDLE.
- A requester must drop req the cycle after ack. A req still high in IDLE is a new request.
- Changing req inputs while not granted is allowed. Only the values sampled at grant matter.
- Asynchronous reset at any point (including ACCESS/RESP):
  - Returns to INIT and drops ack/init_done immediately.
  - The pending access is lost, and the map is re-initialised from address 0.

Decomposition:
- bomberman_pkg holds:
  - TEX_EMPTY=0, TEX_WALL=1, TEX_BRICK=2, TEX_BOMB=3, TEX_FLAME=4
  - MAP_COLS, MAP_ROWS, TILE_LOG2=5, MAP_DEPTH=768
  - FSM state encoding INIT/IDLE/ACCESS/RESP
- One sub-module: tile_map_ram.
  - Dual-port, 768x3.
  - Port A: synchronous read-only, used by the render path.
  - Port B: synchronous read/write, read-first; used by INIT and the arbiter.

Test Plan:
- Release reset and wait for init_done (768 cycles).
  - Read (0,0), (2,2), (1,1), (31,23) via req0.
  - Required rdata: 1, 1, 0, 1.
- req0 write (5,3)=TEX_BRICK, then req1 read (5,3).
  - ack0 comes 2 cycles after sampling; req1 gets rdata=2.
  - Render with hcount=5*32+7, vcount=3*32+1 gives texture_number=2 one cycle later.
- req0 and req1 both high and held for 3 rounds.
  - Grants alternate 0, 1, 0, and ack0/ack1 are never high together.
- Write TEX_BOMB at (3,1) and drive BLINK_FRAMES vsync pulses.
  - inversion=0 before the pulses and 1 after, only over the bomb tile; it toggles back after another BLINK_FRAMES pulses.
- Out-of-range and render boundary checks:
  - Write row=25 → ack issued, map unchanged.
  - Read row=25 → rdata=0.
  - vcount=800 → texture_number=0, inversion=0.
- Assert rst_n low during ACCESS.
  - ack stays 0, init_done=0 immediately.
  - After release, the written tile is back at its default and init_done returns after 768 cycles.

Source files
------------

// File: rtl/bomberman_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : bomberman_pkg                                          |
// | Description : Shared constants, tile codes, controller state type    |
// |               and the default arena layout rule for the tile map.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package bomberman_pkg;

  // Tile codes stored in the map
  localparam logic [2:0] TEX_EMPTY = 3'd0;
  localparam logic [2:0] TEX_WALL  = 3'd1;
  localparam logic [2:0] TEX_BRICK = 3'd2;
  localparam logic [2:0] TEX_BOMB  = 3'd3;
  localparam logic [2:0] TEX_FLAME = 3'd4;

  // Map geometry: 32x24 tiles of 32x32 pixels
  localparam int MAP_COLS  = 32;
  localparam int MAP_ROWS  = 24;
  localparam int TILE_LOG2 = 5;
  localparam int MAP_DEPTH = 768;
  localparam int ADDR_W    = 10;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } map_state_e;

  // Default arena: solid border plus a pillar on every even/even cell.
  // The address is row*32+col, so the row sits in the upper five bits.
  function automatic logic [2:0] default_tile(input logic [ADDR_W-1:0] addr);
    logic [4:0] row;
    logic [4:0] col;
    row = addr[9:5];
    col = addr[4:0];
    if ((row == 5'd0) || (row == 5'(MAP_ROWS - 1)) ||
        (col == 5'd0) || (col == 5'(MAP_COLS - 1)) ||
        (!row[0] && !col[0])) begin
      return TEX_WALL;
    end
    return TEX_EMPTY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_map_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tile_map_ram                                           |
// | Description : 768x3 dual-port tile store.                            |
// |               Port A: synchronous read (renderer).                   |
// |               Port B: synchronous read/write, read-first (controller)|
// | Ports       : clk                                                    |
// |               a_addr_i / a_rdata_o         render read port          |
// |               b_addr_i / b_we_i / b_wdata_i / b_rdata_o  shared port |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tile_map_ram
  import bomberman_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] a_addr_i,
  output logic [2:0]        a_rdata_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic              b_we_i,
  input  logic [2:0]        b_wdata_i,
  output logic [2:0]        b_rdata_o
);

  logic [2:0] mem_q [MAP_DEPTH];

  // Both reads take the pre-write contents, so a same-cycle write to the
  // same address is seen as old data on either port.
  always_ff @(posedge clk) begin
    a_rdata_o <= mem_q[a_addr_i];
    b_rdata_o <= mem_q[b_addr_i];
    if (b_we_i) begin
      mem_q[b_addr_i] <= b_wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tile_map_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tile_map_ctl                                           |
// | Description : Owns the 32x24 tile map. Initialises the arena after   |
// |               reset, serves two game-logic requesters through a      |
// |               round-robin req/ack arbiter, and feeds the renderer    |
// |               with a per-pixel tile code plus bomb-blink inversion.  |
// | Ports       : clk, rst_n (async, active low)                         |
// |               hcount/vcount -> texture_number/inversion (1 cycle)    |
// |               vsync          blink timing                            |
// |               req/we/col/row/wdata 0,1 -> ack0/ack1, rdata           |
// |               init_done      map ready, requests served             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tile_map_ctl
  import bomberman_pkg::TEX_BOMB, bomberman_pkg::TILE_LOG2,
         bomberman_pkg::MAP_DEPTH, bomberman_pkg::ADDR_W,
         bomberman_pkg::map_state_e, bomberman_pkg::INIT,
         bomberman_pkg::IDLE, bomberman_pkg::ACCESS, bomberman_pkg::RESP,
         bomberman_pkg::default_tile;
#(
  parameter int BLINK_FRAMES = 15,
  parameter int MAP_COLS     = 32,
  parameter int MAP_ROWS     = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        vsync,
  output logic [2:0]  texture_number,
  output logic        inversion,
  input  logic        req0,
  input  logic        we0,
  input  logic [4:0]  col0,
  input  logic [4:0]  row0,
  input  logic [2:0]  wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [4:0]  col1,
  input  logic [4:0]  row1,
  input  logic [2:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [2:0]  rdata,
  output logic        init_done
);

  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  map_state_e        state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [4:0]        row_q, row_d;
  logic [4:0]        col_q, col_d;
  logic [2:0]        wdata_q, wdata_d;
  logic [2:0]        rdata_q;

  logic              vsync_q;
  logic [FCW-1:0]    frame_cnt_q;
  logic              blink_q;
  logic              ren_valid_q;
  logic              ren_phase_q;

  logic              w_sel;
  logic              w_row_ok;
  logic [2:0]        w_resp_data;
  logic              w_ren_ok;
  logic [ADDR_W-1:0] w_a_addr;
  logic [2:0]        w_a_rdata;
  logic [ADDR_W-1:0] w_b_addr;
  logic              w_b_we;
  logic [2:0]        w_b_wdata;
  logic [2:0]        w_b_rdata;

  tile_map_ram u_ram (
    .clk       (clk),
    .a_addr_i  (w_a_addr),
    .a_rdata_o (w_a_rdata),
    .b_addr_i  (w_b_addr),
    .b_we_i    (w_b_we),
    .b_wdata_i (w_b_wdata),
    .b_rdata_o (w_b_rdata)
  );

  // ---------------------------------------------------------------------
  // Arbiter / init FSM
  // ---------------------------------------------------------------------
  // With both requesting, the one not served last wins; otherwise the
  // single active requester wins (req1 alone selects 1, req0 alone 0).
  assign w_sel    = (req0 && req1) ? ~last_grant_q : req1;
  assign w_row_ok = (row_q < 5'(MAP_ROWS));

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    init_done_d  = init_done_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    row_d        = row_q;
    col_d        = col_q;
    wdata_d      = wdata_q;
    w_b_addr     = '0;
    w_b_we       = 1'b0;
    w_b_wdata    = '0;

    case (state_q)
      INIT: begin
        w_b_addr  = init_cnt_q;
        w_b_we    = 1'b1;
        w_b_wdata = default_tile(init_cnt_q);
        if (init_cnt_q == ADDR_W'(MAP_DEPTH - 1)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (req0 || req1) begin
          gnt_d        = w_sel;
          last_grant_d = w_sel;
          we_d         = w_sel ? we1    : we0;
          row_d        = w_sel ? row1   : row0;
          col_d        = w_sel ? col1   : col0;
          wdata_d      = w_sel ? wdata1 : wdata0;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        // Off-map rows read address 0 and never write; the response
        // path zeroes their read data.
        w_b_addr  = w_row_ok ? {row_q, col_q} : '0;
        w_b_we    = we_q && w_row_ok;
        w_b_wdata = wdata_q;
        state_d   = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // RAM data for the ACCESS cycle arrives during RESP, so rdata is taken
  // straight from it then and held in rdata_q afterwards.
  assign w_resp_data = (we_q || !w_row_ok) ? 3'd0 : w_b_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      init_done_q  <= 1'b0;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      init_done_q  <= init_done_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      row_q        <= row_d;
      col_q        <= col_d;
      wdata_q      <= wdata_d;
      if (state_q == RESP) begin
        rdata_q <= w_resp_data;
      end
    end
  end

  assign ack0      = (state_q == RESP) && !gnt_q;
  assign ack1      = (state_q == RESP) &&  gnt_q;
  assign rdata     = (state_q == RESP) ? w_resp_data : rdata_q;
  assign init_done = init_done_q;

  // ---------------------------------------------------------------------
  // Bomb blink: toggle phase every BLINK_FRAMES vsync rising edges
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (vsync && !vsync_q) begin
        if (frame_cnt_q == FCW'(BLINK_FRAMES - 1)) begin
          frame_cnt_q <= '0;
          blink_q     <= ~blink_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Render path: RAM port A provides the registered tile; the in-range
  // flag and blink phase are registered alongside so all three line up.
  // ---------------------------------------------------------------------
  assign w_ren_ok = init_done_q &&
                    (hcount < 11'(MAP_COLS << TILE_LOG2)) &&
                    (vcount < 11'(MAP_ROWS << TILE_LOG2));
  assign w_a_addr = w_ren_ok ? {vcount[9:5], hcount[9:5]} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren_valid_q <= 1'b0;
      ren_phase_q <= 1'b0;
    end else begin
      ren_valid_q <= w_ren_ok;
      ren_phase_q <= blink_q;
    end
  end

  assign texture_number = ren_valid_q ? w_a_rdata : 3'd0;
  assign inversion      = ren_valid_q && ren_phase_q && (w_a_rdata == TEX_BOMB);

endmodule
`default_nettype wire

// File: tb/tb_tile_map_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_tile_map_ctl                                        |
// | Description : Scoreboard bench for tile_map_ctl. Accesses push their |
// |               expected ack/rdata into a queue; a monitor pops and    |
// |               compares on every ack. A behavioural map model derives |
// |               all expectations from the arena and arbitration rules. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_tile_map_ctl;
  import bomberman_pkg::*;

  localparam int BF = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount, vcount;
  logic        vsync;
  logic [2:0]  texture_number;
  logic        inversion;
  logic        req0, we0, req1, we1;
  logic [4:0]  col0, row0, col1, row1;
  logic [2:0]  wdata0, wdata1;
  logic        ack0, ack1;
  logic [2:0]  rdata;
  logic        init_done;

  tile_map_ctl #(.BLINK_FRAMES(BF), .MAP_COLS(32), .MAP_ROWS(24)) dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .vsync(vsync),
    .texture_number(texture_number), .inversion(inversion),
    .req0(req0), .we0(we0), .col0(col0), .row0(row0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .col1(col1), .row1(row1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       port;
    logic [2:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  // ---------------- reference model ----------------
  logic [2:0] model_map [768];
  logic       model_last;
  int         vs_pulses;

  function automatic logic [2:0] arena_default(input int col, input int row);
    if (row == 0 || row == 23 || col == 0 || col == 31) return TEX_WALL;
    if ((row % 2 == 0) && (col % 2 == 0)) return TEX_WALL;
    return TEX_EMPTY;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 32; c++)
        model_map[r*32 + c] = arena_default(c, r);
    model_last = 1'b1;
    vs_pulses  = 0;
  endtask

  function automatic logic [2:0] model_read(input int col, input int row);
    if (row >= 24) return 3'd0;
    return model_map[row*32 + col];
  endfunction

  function automatic logic [2:0] model_tex(input int h, input int v);
    if (h >= 1024 || v >= 768) return 3'd0;
    return model_map[(v/32)*32 + h/32];
  endfunction

  function automatic logic model_inv(input int h, input int v);
    return (((vs_pulses / BF) % 2) == 1) && (model_tex(h, v) == TEX_BOMB);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      exp_t e;
      check("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_ack: ack0=%b ack1=%b with nothing outstanding", ack0, ack1);
      end else begin
        e = sb_q.pop_front();
        check("ack_port", {31'd0, ack1}, {31'd0, e.port});
        check("rdata", {29'd0, rdata}, {29'd0, e.rdata});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_port(input logic port, input logic r, input logic w,
                            input int col, input int row, input logic [2:0] wd);
    if (port) begin
      req1 = r; we1 = w; col1 = 5'(col); row1 = 5'(row); wdata1 = wd;
    end else begin
      req0 = r; we0 = w; col0 = 5'(col); row0 = 5'(row); wdata0 = wd;
    end
  endtask

  // Called at a negedge; returns at a negedge with req low for one cycle.
  task automatic access(input logic port, input logic w, input int col, input int row,
                        input logic [2:0] wd, input bit push, input bit chk_lat);
    exp_t e;
    int   cyc;
    logic got;
    if (push) begin
      e.port  = port;
      e.rdata = w ? 3'd0 : model_read(col, row);
      sb_q.push_back(e);
      if (w && row < 24) model_map[row*32 + col] = wd;
      model_last = port;
    end
    drive_port(port, 1'b1, w, col, row, wd);
    cyc = 0;
    got = 1'b0;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      cyc++;
      got = port ? ack1 : ack0;
    end
    drive_port(port, 1'b0, 1'b0, 0, 0, 3'd0);
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: port %0d no ack after %0d cycles", port, cyc);
    end else if (chk_lat) begin
      check("ack_latency", cyc, 2);
    end
    @(negedge clk);
  endtask

  task automatic render_chk(input int h, input int v);
    hcount = 11'(h);
    vcount = 11'(v);
    @(negedge clk);
    check("render_tex", {29'd0, texture_number}, {29'd0, model_tex(h, v)});
    check("render_inv", {31'd0, inversion}, {31'd0, model_inv(h, v)});
  endtask

  task automatic vsync_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
      @(negedge clk);
      vs_pulses++;
    end
  endtask

  task automatic wait_init();
    int c;
    c = 0;
    while (!init_done && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("init_cycles", c, 768);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0[3], r0[3], c1[3], r1[3];
    exp_t  e;
    logic  p;

    rst_n = 1'b1; vsync = 1'b0; hcount = '0; vcount = '0;
    req0 = 0; we0 = 0; col0 = 0; row0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; col1 = 0; row1 = 0; wdata1 = 0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tex", {29'd0, texture_number}, 32'd0);
    check("reset_inv", {31'd0, inversion}, 32'd0);
    check("reset_ack0", {31'd0, ack0}, 32'd0);
    check("reset_ack1", {31'd0, ack1}, 32'd0);
    check("reset_rdata", {29'd0, rdata}, 32'd0);
    check("reset_init_done", {31'd0, init_done}, 32'd0);

    // Requests raised during INIT must wait for init_done
    req0 = 1'b1;
    rst_n = 1'b1;
    req0 = 1'b0;
    wait_init();

    // Default layout spot checks (col,row)
    access(0, 0, 0, 0, 3'd0, 1, 1);
    access(0, 0, 2, 2, 3'd0, 1, 1);
    access(0, 0, 1, 1, 3'd0, 1, 1);
    access(0, 0, 31, 23, 3'd0, 1, 1);

    // Write then cross-port read, then render the written tile
    access(0, 1, 5, 3, TEX_BRICK, 1, 1);
    access(1, 0, 5, 3, 3'd0, 1, 1);
    render_chk(5*32 + 7, 3*32 + 1);

    // Contention: both held, grants alternate starting from the other side
    for (int i = 0; i < 3; i++) begin
      c0[i] = $urandom_range(0, 31); r0[i] = $urandom_range(0, 23);
      c1[i] = $urandom_range(0, 31); r1[i] = $urandom_range(0, 23);
    end
    p = ~model_last;
    for (int k = 0; k < 6; k++) begin
      e.port  = p;
      e.rdata = p ? model_read(c1[k/2], r1[k/2]) : model_read(c0[k/2], r0[k/2]);
      sb_q.push_back(e);
      p = ~p;
    end
    model_last = ~p;
    fork
      begin
        for (int i = 0; i < 3; i++) access(0, 0, c0[i], r0[i], 3'd0, 0, 0);
      end
      begin
        for (int j = 0; j < 3; j++) access(1, 0, c1[j], r1[j], 3'd0, 0, 0);
      end
    join

    // Bomb blink
    access(1, 1, 3, 1, TEX_BOMB, 1, 1);
    render_chk(3*32 + 4, 1*32 + 2);
    vsync_pulses(BF - 1);
    render_chk(3*32 + 4, 1*32 + 2);
    vsync_pulses(1);
    render_chk(3*32 + 4, 1*32 + 2);
    render_chk(4*32 + 4, 1*32 + 2);
    vsync_pulses(BF);
    render_chk(3*32 + 31, 1*32 + 31);

    // Out-of-range requests and render boundaries
    access(0, 1, 5, 25, TEX_FLAME, 1, 1);
    access(0, 0, 5, 1, 3'd0, 1, 1);
    access(1, 0, 5, 25, 3'd0, 1, 1);
    render_chk(3*32 + 4, 800);
    render_chk(1024, 100);
    render_chk(1023, 767);
    render_chk(2047, 2047);

    // Randomised accesses and renders
    for (int i = 0; i < 40; i++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 31), $urandom_range(0, 27),
             3'($urandom_range(0, 7)), 1, 1);
    end
    vsync_pulses(BF);
    for (int i = 0; i < 40; i++) begin
      render_chk($urandom_range(0, 1100), $urandom_range(0, 820));
    end

    // Reset in the middle of an access
    @(negedge clk);
    drive_port(0, 1'b1, 1'b1, 4, 5, TEX_FLAME);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_ack0", {31'd0, ack0}, 32'd0);
    check("midreset_init_done", {31'd0, init_done}, 32'd0);
    check("midreset_tex", {29'd0, texture_number}, 32'd0);
    drive_port(0, 1'b0, 1'b0, 0, 0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    check("midreset_ack0_held", {31'd0, ack0}, 32'd0);
    model_reset();
    rst_n = 1'b1;
    wait_init();
    access(0, 0, 4, 5, 3'd0, 1, 1);
    render_chk(4*32, 5*32);
    render_chk(3*32 + 4, 1*32 + 2);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
